// File: rtl/master_nios_slave_int_tx.sv
// master_nios_slave_int_tx
// Slave-side interrupt transmitter. The local Nios writes request bits over
// Avalon-MM. Each request produces one high pulse on out_port[i], which feeds
// the master's falling-edge capture input. Every pulse is followed by a
// minimum low gap so the master can re-arm. Per-channel pending counters
// queue back-to-back requests.
// Register map: 0 request / out_port, 1 cancel / {ovf, busy},
//               2 done_mask, 3 done_cap (any write clears it).
// Optional feature macro: SLAVE_INT_TX_DONE_IRQ_EN adds the done_mask register
// and drives irq. When the macro is absent, irq is tied low and address 2
// reads as zero.
module master_nios_slave_int_tx #(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TMR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [TMR_W-1:0] tmr_q   [WIDTH];
  logic [TMR_W-1:0] tmr_d   [WIDTH];
  logic [CNT_W-1:0] pend_q  [WIDTH];
  logic [CNT_W-1:0] pend_d  [WIDTH];
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0] done_cap_q, done_cap_d;
  logic [WIDTH-1:0] start, gap_end, busy;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr;
  logic [WIDTH-1:0] req, cancel;
  logic             done_clr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign req          = (wr && address == 2'd0) ? writedata[WIDTH-1:0] : '0;
  assign cancel       = (wr && address == 2'd1) ? writedata[WIDTH-1:0] : '0;
  assign done_clr     = wr && (address == 2'd3);
  assign unused_wdata = ^writedata[31:WIDTH];

  // Per-channel pulse FSM plus pending-counter and sticky-flag bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    tmr_d      = tmr_q;
    pend_d     = pend_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    done_cap_d = done_clr ? '0 : done_cap_q;
    start      = '0;
    gap_end    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (pend_q[i] != '0) begin
            state_d[i] = ST_HIGH;
            out_d[i]   = 1'b1;
            tmr_d[i]   = TMR_W'(PULSE_W - 1);
            start[i]   = 1'b1;
          end
        end
        ST_HIGH: begin
          if (tmr_q[i] != '0) begin
            tmr_d[i] = tmr_q[i] - 1'b1;
          end else begin
            state_d[i] = ST_LOW;
            out_d[i]   = 1'b0;
            tmr_d[i]   = TMR_W'(GAP_W - 1);
          end
        end
        ST_LOW: begin
          if (tmr_q[i] != '0) begin
            tmr_d[i] = tmr_q[i] - 1'b1;
          end else begin
            state_d[i] = ST_IDLE;
            gap_end[i] = 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          out_d[i]   = 1'b0;
        end
      endcase

      // Cancel drops only queued requests; a pulse already launched runs on.
      // A request and a launch in the same cycle cancel each other out.
      if (cancel[i]) begin
        pend_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end else if (req[i] && !start[i]) begin
        if (pend_q[i] == PEND_MAX) ovf_d[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + 1'b1;
      end else if (start[i] && !req[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end

      // Done fires only when the queue has drained. A new done event wins over
      // a simultaneous clear so that the event is never lost.
      if (gap_end[i] && pend_d[i] == '0) done_cap_d[i] = 1'b1;
    end
  end

  // A channel is busy while requests are queued or a pulse/gap is running.
  always_comb begin
    busy = '0;
    for (int i = 0; i < WIDTH; i++) begin
      busy[i] = (pend_q[i] != '0) || (state_q[i] != ST_IDLE);
    end
  end

`ifdef SLAVE_INT_TX_DONE_IRQ_EN
  logic [WIDTH-1:0] done_mask_q, done_mask_d;

  // Done-interrupt mask register.
  always_comb begin
    done_mask_d = done_mask_q;
    if (wr && address == 2'd2) done_mask_d = writedata[WIDTH-1:0];
  end

  // Mask storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_mask_q <= '0;
    else          done_mask_q <= done_mask_d;
  end

  assign irq = |(done_cap_q & done_mask_q);
`else
  assign irq = 1'b0;
`endif

  // Read mux. It is sampled every cycle without a chipselect qualifier, so the
  // read latency is 1.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: readdata_d = 32'(out_q);
      2'd1: readdata_d = 32'({ovf_q, busy});
`ifdef SLAVE_INT_TX_DONE_IRQ_EN
      2'd2: readdata_d = 32'(done_mask_q);
`else
      2'd2: readdata_d = '0;
`endif
      2'd3: readdata_d = 32'(done_cap_q);
    endcase
  end

  // State registers. Reset kills any pulse in flight and drops the queues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-channel arrays are a handful of flops, not a RAM, and
      // must all start empty, so every entry is reset explicitly.
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_IDLE;
        tmr_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      out_q      <= '0;
      ovf_q      <= '0;
      done_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop updates from
      // values taken before the edge, whatever the statement order.
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      done_cap_q <= done_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port = out_q;
  assign readdata = readdata_q;

endmodule
